// File: rtl/uart_loader_ram_if.sv
// Loader bus: serial line, mode button, CPU fetch port and status outputs.
// master = environment / CPU side, slave = loader.
interface uart_loader_ram_if #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 8
);
    localparam int DATA_W = 8 * WORD_BYTES;

    logic              rx;
    logic              button;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              mode;
    logic [ADDR_W:0]   word_count;
    logic              frame_err;

    modport master (
        output rx, button, rd_addr,
        input  rd_data, mode, word_count, frame_err
    );

    modport slave (
        input  rx, button, rd_addr,
        output rd_data, mode, word_count, frame_err
    );
endinterface

// File: rtl/uart_loader_ram.sv
// UART 8N1 program loader into a single-port word memory; 1-cycle registered read in run mode.
// Word write lands one edge after the last byte's stop sample; no backpressure (free-running line).
module uart_loader_ram #(
    parameter int CLKS_PER_BIT = 234,
    parameter int WORD_BYTES   = 2,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input logic              clk,
    input logic              reset,
    uart_loader_ram_if.slave ldr_io
);
    localparam int DATA_W  = 8 * WORD_BYTES;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam int K_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]   WC_MAX   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    logic [1:0]        rx_sync_q;
    logic              rx_prev_q;
    logic [1:0]        btn_sync_q;
    logic              btn_prev_q;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [K_W-1:0]    k_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic              wr_pend_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W:0]   word_count_q;
    logic              frame_err_q;
    logic              mode_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [TMO_W-1:0]  tmo_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic rx_s;
    logic rx_fall;
    logic btn_fall;
    logic stop_smp;
    logic byte_ok;
    logic stop_bad;

    assign rx_s     = rx_sync_q[1];
    assign rx_fall  = rx_prev_q & ~rx_s;
    assign btn_fall = btn_prev_q & ~btn_sync_q[1];
    assign stop_smp = (state_q == RX_STOP) && (cnt_q == FULL_BIT);
    assign byte_ok  = stop_smp & rx_s;
    assign stop_bad = stop_smp & ~rx_s;

    // Little-endian lane insert of the just-received byte.
    always_comb begin
        word_d = word_q;
        word_d[{k_q, 3'b000} +: 8] = shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
            btn_sync_q   <= 2'b11;
            btn_prev_q   <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            k_q          <= '0;
            word_q       <= '0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
            mode_q       <= 1'b0;
            rd_data_q    <= '0;
            tmo_q        <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], ldr_io.rx};
            rx_prev_q  <= rx_s;
            btn_sync_q <= {btn_sync_q[0], ldr_io.button};
            btn_prev_q <= btn_sync_q[1];
            wr_pend_q  <= 1'b0;

            unique case (state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_BIT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    // Restart at 1 so consecutive samples are exactly one bit apart.
                    if (cnt_q == FULL_BIT) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= CNT_W'(1);
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_BIT) begin
                        state_q <= RX_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase

            if (k_q == '0 || byte_ok) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_q <= '0;
                k_q   <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (byte_ok && !mode_q) begin
                word_q <= word_d;
                if (k_q == K_LAST) begin
                    k_q       <= '0;
                    wr_pend_q <= 1'b1;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end

            if (stop_bad) begin
                frame_err_q <= 1'b1;
                k_q         <= '0;
            end

            // A pending write was committed in load mode, so it completes even if mode just flipped.
            if (wr_pend_q) begin
                wr_addr_q <= wr_addr_q + 1'b1;
                if (word_count_q != WC_MAX) begin
                    word_count_q <= word_count_q + 1'b1;
                end
            end

            if (btn_fall) begin
                mode_q <= ~mode_q;
                k_q    <= '0;
                tmo_q  <= '0;
                if (mode_q) begin
                    wr_addr_q    <= '0;
                    word_count_q <= '0;
                    frame_err_q  <= 1'b0;
                end
            end

            rd_data_q <= mode_q ? mem_q[ldr_io.rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend_q && !reset) begin
            mem_q[wr_addr_q] <= word_q;
        end
    end

    assign ldr_io.rd_data    = rd_data_q;
    assign ldr_io.mode       = mode_q;
    assign ldr_io.word_count = word_count_q;
    assign ldr_io.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_loader_ram.sv
// Scoreboard bench for uart_loader_ram: stimulus queues expectations, a negedge monitor pops and compares.
module tb_uart_loader_ram;
    localparam int CPB = 16;
    localparam int WB  = 2;
    localparam int AW  = 4;
    localparam int TB  = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_loader_ram_if #(.WORD_BYTES(WB), .ADDR_W(AW)) bus ();

    uart_loader_ram #(
        .CLKS_PER_BIT(CPB),
        .WORD_BYTES  (WB),
        .ADDR_W      (AW),
        .TIMEOUT_BITS(TB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ldr_io(bus)
    );

    typedef struct {
        int          due;
        int          sel;
        int          tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   tagn     = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       return 32'(bus.rd_data);
            1:       return 32'(bus.mode);
            2:       return 32'(bus.word_count);
            default: return 32'(bus.frame_err);
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            0:       return "rd_data";
            1:       return "mode";
            2:       return "word_count";
            default: return "frame_err";
        endcase
    endfunction

    // Monitor: one expectation per cycle once it is due.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = sample(e.sel);
            checks++;
            if (got !== e.exp) begin
                failures++;
                $display("FAIL %s#%0d got=%0h exp=%0h", sel_name(e.sel), e.tag, got, e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] exp);
        sb.push_back('{cyc + 1, sel, tagn, exp});
        tagn++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic status(input logic m, input int wc, input logic fe);
        expect_val(1, 32'(m));
        expect_val(2, 32'(wc));
        expect_val(3, 32'(fe));
        drain();
    endtask

    task automatic rd(input int addr, input logic [31:0] exp);
        drain();
        @(negedge clk);
        bus.rd_addr = AW'(addr);
        expect_val(0, exp);
        drain();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            idle(CPB);
        end
        bus.rx = stop;
        idle(CPB);
        bus.rx = 1'b1;
        idle(2);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic press();
        @(negedge clk);
        bus.button = 1'b0;
        idle(4);
        bus.button = 1'b1;
        idle(4);
    endtask

    task automatic send_reset_mid(input logic [7:0] b);
        @(negedge clk);
        bus.rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) reset = 1'b1;
            bus.rx = b[i];
            idle(CPB);
        end
        bus.rx = 1'b1;
        idle(CPB + 2);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.rx      = 1'b1;
        bus.button  = 1'b1;
        bus.rd_addr = '0;
        idle(5);
        reset = 1'b0;
        idle(1);

        // Reset state
        status(1'b0, 0, 1'b0);
        expect_val(0, 32'h0);
        drain();

        // Basic load of two words, then run-mode reads
        send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
        idle(5);
        status(1'b0, 2, 1'b0);
        expect_val(0, 32'h0);
        press();
        status(1'b1, 2, 1'b0);
        rd(0, 32'h1234);
        rd(1, 32'hABCD);

        // Glitch rejection and framing error
        press();
        status(1'b0, 0, 1'b0);
        @(negedge clk);
        bus.rx = 1'b0;
        idle(3);
        bus.rx = 1'b1;
        idle(40);
        status(1'b0, 0, 1'b0);
        send_frame(8'h55, 1'b0);
        idle(5);
        status(1'b0, 0, 1'b1);
        send(8'h66); send(8'h77);
        idle(5);
        status(1'b0, 1, 1'b1);
        press();
        rd(0, 32'h7766);
        rd(1, 32'hABCD);

        // Inter-byte timeout drops the partial word
        press();
        status(1'b0, 0, 1'b0);
        send(8'h11);
        idle(TB * CPB + 5);
        send(8'h22); send(8'h33);
        idle(5);
        status(1'b0, 1, 1'b0);
        press();
        rd(0, 32'h3322);

        // Address wrap and word_count saturation
        press();
        for (int i = 0; i < 17; i++) begin
            send(8'(i));
            send(8'h00);
        end
        idle(5);
        status(1'b0, 16, 1'b0);
        press();
        rd(0, 32'h0010);
        rd(1, 32'h0001);
        rd(15, 32'h000F);

        // Run mode ignores bytes; re-entering load restarts at address 0
        send(8'hAA); send(8'hBB);
        idle(5);
        status(1'b1, 16, 1'b0);
        rd(0, 32'h0010);
        rd(1, 32'h0001);
        press();
        status(1'b0, 0, 1'b0);
        send(8'hEF); send(8'hBE);
        idle(5);
        press();
        rd(0, 32'hBEEF);
        rd(1, 32'h0001);

        // Reset mid-frame with a partial word pending
        press();
        send(8'h99); send(8'h88);
        idle(5);
        status(1'b0, 1, 1'b0);
        send(8'h77);
        send_reset_mid(8'h44);
        status(1'b0, 0, 1'b0);
        expect_val(0, 32'h0);
        drain();
        send(8'h21); send(8'h43);
        idle(5);
        status(1'b0, 1, 1'b0);
        press();
        rd(0, 32'h4321);
        rd(1, 32'h0001);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
